// File: rtl/frame_store.sv
// -----------------------------------------------------------------------------
// frame_store
//
// Purpose:
//   Stores RGB pixels for a rectangular window of the screen
//   (X0..X0+WIN_W-1, Y0..Y0+WIN_H-1) and returns the stored pixel for the
//   current raster position one cycle later. An optional clear engine
//   sweeps the whole window to CLR_VAL, one address per cycle.
//
// Configuration:
//   FRAME_STORE_CLEAR_EN  defined   -> two-state clear FSM (IDLE/CLEAR).
//                         undefined -> no FSM, ClearReq ignored, Busy tied 0.
//
// Ports:
//   Clk         in   single clock, rising edge
//   Reset       in   asynchronous, active-high reset
//   xPos, yPos  in   current pixel column / row (10 bits)
//   WrEn        in   write Ri/Gi/Bi at the current pixel
//   Ri, Gi, Bi  in   pixel data to store (CW bits each)
//   ClearReq    in   single-cycle pulse starting a full-window clear
//   Ro, Go, Bo  out  stored pixel data, registered (0 outside the window)
//   InWin       out  registered: Ro/Go/Bo belong to an in-window pixel
//   Busy        out  a clear is in progress
// -----------------------------------------------------------------------------
module frame_store #(
  parameter int X0      = 100,
  parameter int Y0      = 100,
  parameter int WIN_W   = 440,
  parameter int WIN_H   = 280,
  parameter int CW      = 8,
  parameter int CLR_VAL = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [9:0]    xPos,
  input  logic [9:0]    yPos,
  input  logic          WrEn,
  input  logic [CW-1:0] Ri,
  input  logic [CW-1:0] Gi,
  input  logic [CW-1:0] Bi,
  input  logic          ClearReq,
  output logic [CW-1:0] Ro,
  output logic [CW-1:0] Go,
  output logic [CW-1:0] Bo,
  output logic          InWin,
  output logic          Busy
);

  localparam int DEPTH = WIN_W * WIN_H;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Window bounds widened to 11 bits so X0+WIN_W cannot wrap.
  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + WIN_W);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + WIN_H);

  localparam logic [CW-1:0] CLR_PIX = CW'(CLR_VAL);

  // ---------------------------------------------------------------------------
  // Window test and linear address
  // ---------------------------------------------------------------------------
  logic [10:0]   x_ext, y_ext;
  logic          pix_in_win;
  logic [AW-1:0] pix_addr;

  assign x_ext = {1'b0, xPos};
  assign y_ext = {1'b0, yPos};

  always_comb begin
    pix_in_win = (x_ext >= X_LO) && (x_ext < X_HI) &&
                 (y_ext >= Y_LO) && (y_ext < Y_HI);
    // Only meaningful when pix_in_win; modular AW-bit arithmetic keeps the
    // low bits exact for in-window offsets.
    pix_addr   = AW'(y_ext - Y_LO) * AW'(WIN_W) + AW'(x_ext - X_LO);
  end

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  logic          idle;
  logic          clearing;
  logic [AW-1:0] clr_addr;

`ifdef FRAME_STORE_CLEAR_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e        state_q;
  logic [AW-1:0] clr_addr_q;
  logic          busy_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      clr_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ClearReq) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        S_CLEAR: begin
          // The last address is written in this same cycle, so Busy drops
          // on the cycle right after it.
          if (clr_addr_q == AW'(DEPTH - 1)) begin
            state_q    <= S_IDLE;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + AW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign idle     = (state_q == S_IDLE);
  assign clearing = (state_q == S_CLEAR);
  assign clr_addr = clr_addr_q;
  assign Busy     = busy_q;
`else
  logic [CW:0] unused_clear;

  assign idle         = 1'b1;
  assign clearing     = 1'b0;
  assign clr_addr     = '0;
  assign Busy         = 1'b0;
  assign unused_clear = {ClearReq, CLR_PIX};
`endif

  // ---------------------------------------------------------------------------
  // Storage: write port (clear sweep has priority over pixel writes)
  // ---------------------------------------------------------------------------
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [CW-1:0] mem_wr, mem_wg, mem_wb;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = pix_addr;
    mem_wr    = Ri;
    mem_wg    = Gi;
    mem_wb    = Bi;
    if (clearing) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wr    = CLR_PIX;
      mem_wg    = CLR_PIX;
      mem_wb    = CLR_PIX;
    end else begin
      mem_we    = WrEn && pix_in_win && idle;
    end
  end

  logic [CW-1:0] r_mem [DEPTH];
  logic [CW-1:0] g_mem [DEPTH];
  logic [CW-1:0] b_mem [DEPTH];

  // NOTE: the arrays carry no reset so they map onto plain RAM; contents
  // after power-up or a reset are whatever was last written.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      r_mem[mem_waddr] <= mem_wr;
      g_mem[mem_waddr] <= mem_wg;
      b_mem[mem_waddr] <= mem_wb;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------------
  logic          in_win_d, in_win_q;
  logic [CW-1:0] ro_d, go_d, bo_d;
  logic [CW-1:0] ro_q, go_q, bo_q;

  // NOTE: the read samples the array before this edge's write lands, so a
  // same-address read and write returns the old data (read-before-write).
  always_comb begin
    in_win_d = idle && pix_in_win;
    ro_d     = '0;
    go_d     = '0;
    bo_d     = '0;
    if (in_win_d) begin
      ro_d = r_mem[pix_addr];
      go_d = g_mem[pix_addr];
      bo_d = b_mem[pix_addr];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      in_win_q <= 1'b0;
      ro_q     <= '0;
      go_q     <= '0;
      bo_q     <= '0;
    end else begin
      in_win_q <= in_win_d;
      ro_q     <= ro_d;
      go_q     <= go_d;
      bo_q     <= bo_d;
    end
  end

  assign InWin = in_win_q;
  assign Ro    = ro_q;
  assign Go    = go_q;
  assign Bo    = bo_q;

endmodule

// File: tb/tb_frame_store.sv
// -----------------------------------------------------------------------------
// tb_frame_store
//
// Directed bench for frame_store with a 4x2 window at (2,1). Pixel address
// a maps to (x,y) = (2 + a%4, 1 + a/4). A shadow copy of the 8 stored
// pixels holds the expected memory contents.
// -----------------------------------------------------------------------------
module tb_frame_store;

  localparam int          X0      = 2;
  localparam int          Y0      = 1;
  localparam int          WIN_W   = 4;
  localparam int          WIN_H   = 2;
  localparam int          CW      = 8;
  localparam logic [7:0]  CLR_PIX = 8'h5A;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] xPos, yPos;
  logic       WrEn;
  logic [7:0] Ri, Gi, Bi;
  logic       ClearReq;
  logic [7:0] Ro, Go, Bo;
  logic       InWin;
  logic       Busy;

  frame_store #(
    .X0(X0), .Y0(Y0), .WIN_W(WIN_W), .WIN_H(WIN_H), .CW(CW),
    .CLR_VAL(int'(CLR_PIX))
  ) dut (
    .Clk(Clk), .Reset(Reset), .xPos(xPos), .yPos(yPos), .WrEn(WrEn),
    .Ri(Ri), .Gi(Gi), .Bi(Bi), .ClearReq(ClearReq),
    .Ro(Ro), .Go(Go), .Bo(Bo), .InWin(InWin), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_r [8];
  logic [7:0] m_g [8];
  logic [7:0] m_b [8];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input int x, input int y, input logic we,
                       input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic clr);
    xPos     = 10'(x);
    yPos     = 10'(y);
    WrEn     = we;
    Ri       = r;
    Gi       = g;
    Bi       = b;
    ClearReq = clr;
    @(posedge Clk);
    #1;
    WrEn     = 1'b0;
    ClearReq = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b,
                           input logic iw);
    check({tag, "_r"}, 32'(Ro), 32'(r));
    check({tag, "_g"}, 32'(Go), 32'(g));
    check({tag, "_b"}, 32'(Bo), 32'(b));
    check({tag, "_inwin"}, 32'(InWin), 32'(iw));
  endtask

  task automatic write_px(input int a, input logic [7:0] r,
                          input logic [7:0] g, input logic [7:0] b);
    drive(X0 + a % WIN_W, Y0 + a / WIN_W, 1'b1, r, g, b, 1'b0);
    m_r[a] = r;
    m_g[a] = g;
    m_b[a] = b;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 8; a++) begin
      drive(X0 + a % WIN_W, Y0 + a / WIN_W, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      check_out($sformatf("%s_a%0d", tag, a), m_r[a], m_g[a], m_b[a], 1'b1);
    end
  endtask

  initial begin
    Reset    = 1'b1;
    xPos     = '0;
    yPos     = '0;
    WrEn     = 1'b0;
    Ri       = '0;
    Gi       = '0;
    Bi       = '0;
    ClearReq = 1'b0;

    // Reset state
    #12;
    check_out("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    check("reset_busy", 32'(Busy), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Preload every window pixel with a distinct value, then read back
    for (int a = 0; a < 8; a++)
      write_px(a, 8'h10 + 8'(a), 8'h20 + 8'(a), 8'h30 + 8'(a));
    read_all("pre");

    // Write (3,1) = addr 1: same-cycle output is the old 11h/21h/31h
    drive(3, 1, 1'b1, 8'd11, 8'd22, 8'd33, 1'b0);
    check_out("wr31_old", 8'h11, 8'h21, 8'h31, 1'b1);
    drive(3, 1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    check_out("rd31", 8'd11, 8'd22, 8'd33, 1'b1);
    m_r[1] = 8'd11; m_g[1] = 8'd22; m_b[1] = 8'd33;

    // Read-before-write at (5,2) = addr 7
    drive(5, 2, 1'b1, 8'd44, 8'd44, 8'd44, 1'b0);
    check_out("wr52_a", 8'h17, 8'h27, 8'h37, 1'b1);
    drive(5, 2, 1'b1, 8'd55, 8'd55, 8'd55, 1'b0);
    check_out("rbw52", 8'd44, 8'd44, 8'd44, 1'b1);
    drive(5, 2, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    check_out("rd52", 8'd55, 8'd55, 8'd55, 1'b1);
    m_r[7] = 8'd55; m_g[7] = 8'd55; m_b[7] = 8'd55;

    // Out-of-window writes: outputs zero, memory untouched
    drive(1, 1, 1'b1, 8'hAA, 8'hAA, 8'hAA, 1'b0);
    check_out("oob_1_1", 8'h00, 8'h00, 8'h00, 1'b0);
    drive(6, 1, 1'b1, 8'hAA, 8'hAA, 8'hAA, 1'b0);
    check_out("oob_6_1", 8'h00, 8'h00, 8'h00, 1'b0);
    drive(2, 3, 1'b1, 8'hAA, 8'hAA, 8'hAA, 1'b0);
    check_out("oob_2_3", 8'h00, 8'h00, 8'h00, 1'b0);
    drive(2, 0, 1'b1, 8'hAA, 8'hAA, 8'hAA, 1'b0);
    check_out("oob_2_0", 8'h00, 8'h00, 8'h00, 1'b0);
    drive(1023, 1, 1'b1, 8'hAA, 8'hAA, 8'hAA, 1'b0);
    check_out("oob_1023_1", 8'h00, 8'h00, 8'h00, 1'b0);
    read_all("bnd");

`ifdef FRAME_STORE_CLEAR_EN
    begin
      int busy_cnt;
      // Trigger edge: still IDLE, so (4,1)=addr 2 is read normally
      drive(4, 1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
      check_out("clr_trig", 8'h12, 8'h22, 8'h32, 1'b1);
      check("clr_busy_on", 32'(Busy), 32'd1);
      busy_cnt = (Busy === 1'b1) ? 1 : 0;
      // Seven more sweep cycles with writes and ClearReq that must be ignored
      for (int i = 0; i < 7; i++) begin
        drive(X0 + i % WIN_W, Y0 + i / WIN_W, 1'b1, 8'h99, 8'h99, 8'h99,
              1'(i % 2));
        check_out($sformatf("clr_cyc%0d", i), 8'h00, 8'h00, 8'h00, 1'b0);
        if (Busy === 1'b1) busy_cnt++;
      end
      check("clr_busy_mid", 32'(Busy), 32'd1);
      // Edge that writes the last address: Busy drops right after it
      drive(4, 1, 1'b1, 8'h99, 8'h99, 8'h99, 1'b1);
      check_out("clr_last", 8'h00, 8'h00, 8'h00, 1'b0);
      check("clr_busy_off", 32'(Busy), 32'd0);
      check("clr_busy_cycles", 32'(busy_cnt), 32'd8);
      drive(4, 1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      check("clr_busy_stays", 32'(Busy), 32'd0);
      for (int a = 0; a < 8; a++) begin
        m_r[a] = CLR_PIX; m_g[a] = CLR_PIX; m_b[a] = CLR_PIX;
      end
      read_all("clr");

      // Reset partway through a clear
      for (int a = 0; a < 8; a++)
        write_px(a, 8'h60 + 8'(a), 8'h70 + 8'(a), 8'h80 + 8'(a));
      // ClearReq together with a write at (3,2)=addr 5: write still happens
      drive(3, 2, 1'b1, 8'hC5, 8'hC6, 8'hC7, 1'b1);
      check_out("rst_trig", 8'h65, 8'h75, 8'h85, 1'b1);
      m_r[5] = 8'hC5; m_g[5] = 8'hC6; m_b[5] = 8'hC7;
      for (int i = 0; i < 3; i++)
        drive(4, 2, 1'b1, 8'h99, 8'h99, 8'h99, 1'b0);
      check("rst_busy_before", 32'(Busy), 32'd1);
      Reset = 1'b1;
      #1;
      check("rst_busy_after", 32'(Busy), 32'd0);
      check_out("rst_out", 8'h00, 8'h00, 8'h00, 1'b0);
      @(negedge Clk);
      Reset = 1'b0;
      for (int a = 0; a < 3; a++) begin
        m_r[a] = CLR_PIX; m_g[a] = CLR_PIX; m_b[a] = CLR_PIX;
      end
      read_all("rst");
    end
`else
    // Clear engine absent: ClearReq has no effect
    drive(3, 1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check_out("noclr_trig", 8'd11, 8'd22, 8'd33, 1'b1);
    check("noclr_busy0", 32'(Busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(5, 2, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      check($sformatf("noclr_busy%0d", i + 1), 32'(Busy), 32'd0);
    end
    read_all("noclr");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
